// File: rtl/sdram_chk_report_if.sv
// Reporter bundle: checker stop/error levels in; UART line and pass/fail statistics out.
interface sdram_chk_report_if;
  logic        i_stop;
  logic        i_error;
  logic        o_txd;
  logic        o_busy;
  logic        o_drop;
  logic [15:0] o_pass_cnt;
  logic [15:0] o_fail_cnt;

  modport master (
    output i_stop, i_error,
    input  o_txd, o_busy, o_drop, o_pass_cnt, o_fail_cnt
  );

  modport slave (
    input  i_stop, i_error,
    output o_txd, o_busy, o_drop, o_pass_cnt, o_fail_cnt
  );
endinterface

// File: rtl/sdram_chk_report.sv
// SDRAM checker status reporter: counts pass/fail stop events and sends
// "PASS hhhh\r\n" / "FAIL hhhh\r\n" over an 8N1 UART line.
module sdram_chk_report #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              w_clk0_out,
  input  logic              reset_n,
  sdram_chk_report_if.slave rpt_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  IDX_LAST = 4'd10;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = 8'h37 + {4'h0, nib};
    end
    return ch;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [3:0] idx, input logic err,
                                          input logic [15:0] run);
    logic [7:0] b;
    case (idx)
      4'd0:    b = err ? 8'h46 : 8'h50;
      4'd1:    b = 8'h41;
      4'd2:    b = err ? 8'h49 : 8'h53;
      4'd3:    b = err ? 8'h4C : 8'h53;
      4'd4:    b = 8'h20;
      4'd5:    b = hex_ascii(run[15:12]);
      4'd6:    b = hex_ascii(run[11:8]);
      4'd7:    b = hex_ascii(run[7:4]);
      4'd8:    b = hex_ascii(run[3:0]);
      4'd9:    b = 8'h0D;
      4'd10:   b = 8'h0A;
      default: b = 8'h20;
    endcase
    return b;
  endfunction

  state_e      state_q, state_d;
  logic        stop_q;
  logic        stop_evt_s;
  logic [15:0] run_q, run_d;
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic        drop_q, drop_d;
  logic        busy_q, busy_d;
  logic        txd_q, txd_d;
  logic        snap_err_q, snap_err_d;
  logic [15:0] snap_run_q, snap_run_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  shift_q, shift_d;

  assign stop_evt_s = rpt_if.i_stop & ~stop_q;

  // Statistics: every stop event counts, even when the line is busy.
  always_comb begin
    run_d      = run_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    drop_d     = drop_q;
    if (stop_evt_s) begin
      run_d = run_q + 16'd1;
      if (rpt_if.i_error) begin
        fail_cnt_d = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;
      end else begin
        pass_cnt_d = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
      end
      drop_d = drop_q | (state_q != S_IDLE);
    end else begin
      drop_d = drop_q;
    end
  end

  // Message sequencer: next state, bit timing and next line level.
  always_comb begin
    state_d    = state_q;
    snap_err_d = snap_err_q;
    snap_run_d = snap_run_q;
    idx_d      = idx_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    txd_d      = 1'b1;
    busy_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stop_evt_s) begin
          state_d    = S_LOAD;
          snap_err_d = rpt_if.i_error;
          snap_run_d = run_d;
          idx_d      = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shift_d = msg_byte(idx_q, snap_err_q, snap_run_q);
        timer_d = BIT_LAST;
        state_d = S_START;
      end
      S_START: begin
        if (timer_q == 16'd0) begin
          timer_d   = BIT_LAST;
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = BIT_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (timer_q == 16'd0) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so o_txd leaves a flop.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge w_clk0_out or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; the line idles high through reset.
  always_ff @(posedge w_clk0_out or negedge reset_n) begin
    if (!reset_n) begin
      stop_q     <= 1'b0;
      run_q      <= 16'd0;
      pass_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      txd_q      <= 1'b1;
      snap_err_q <= 1'b0;
      snap_run_q <= 16'd0;
      idx_q      <= 4'd0;
      bit_cnt_q  <= 3'd0;
      timer_q    <= 16'd0;
      shift_q    <= 8'd0;
    end else begin
      stop_q     <= rpt_if.i_stop;
      run_q      <= run_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      txd_q      <= txd_d;
      snap_err_q <= snap_err_d;
      snap_run_q <= snap_run_d;
      idx_q      <= idx_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
    end
  end

  assign rpt_if.o_txd      = txd_q;
  assign rpt_if.o_busy     = busy_q;
  assign rpt_if.o_drop     = drop_q;
  assign rpt_if.o_pass_cnt = pass_cnt_q;
  assign rpt_if.o_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_sdram_chk_report.sv
// Directed bench for sdram_chk_report: decodes the UART line and checks messages,
// statistics, overlap drop, wrap/saturation, reset mid-frame and stuck-high stop.
module tb_sdram_chk_report;

  localparam int CPB = 4;

  typedef struct {
    logic        preset;
    logic [15:0] run_pre;
    logic [15:0] pass_pre;
    logic        err;
    logic [87:0] msg;
    logic [15:0] pass;
    logic [15:0] fail;
    logic        drop;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   rx_idx = 0;
  logic [15:0] f_run;
  logic [15:0] f_pass;
  vec_t vecs [6];

  sdram_chk_report_if bus ();

  sdram_chk_report #(.CLKS_PER_BIT(CPB)) dut (
    .w_clk0_out (clk),
    .reset_n    (rst_n),
    .rpt_if     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Receive 11 bytes; returns the cycle of the first start bit.
  task automatic rx_msg(output logic [87:0] msg, output int start_cyc, output bit ok);
    int w;
    ok = 1'b1;
    msg = '0;
    start_cyc = 0;
    for (int b = 0; b < 11; b++) begin
      rx_idx = b;
      w = 0;
      while (bus.o_txd !== 1'b0 && w < 5000) begin
        @(negedge clk);
        w++;
      end
      if (bus.o_txd !== 1'b0) begin
        ok = 1'b0;
        return;
      end
      if (b == 0) start_cyc = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        msg[80 - 8 * b + k] = bus.o_txd;
      end
      repeat (CPB) @(negedge clk);
      if (bus.o_txd !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name, input int sc);
    int w;
    w = 0;
    while (bus.o_busy !== 1'b0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_busy_len"}, 88'(cyc - sc), 88'(450));
  endtask

  task automatic count_starts(input int n, output int starts);
    starts = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus.o_txd === 1'b0) starts++;
    end
  endtask

  task automatic run_vec(input int i);
    logic [87:0] m;
    int sc;
    bit ok;
    string nm;
    nm = $sformatf("v%0d", i);
    bus.i_stop  = 1'b0;
    bus.i_error = vecs[i].err;
    @(negedge clk);
    if (vecs[i].preset) begin
      f_run  = vecs[i].run_pre;
      f_pass = vecs[i].pass_pre;
      force dut.run_q = f_run;
      force dut.pass_cnt_q = f_pass;
      @(negedge clk);
      release dut.run_q;
      release dut.pass_cnt_q;
    end
    bus.i_stop = 1'b1;
    @(negedge clk);
    chk({nm, "_busy_load"}, 88'(bus.o_busy), 88'(1));
    chk({nm, "_txd_load"}, 88'(bus.o_txd), 88'(1));
    chk({nm, "_pass"}, 88'(bus.o_pass_cnt), 88'(vecs[i].pass));
    chk({nm, "_fail"}, 88'(bus.o_fail_cnt), 88'(vecs[i].fail));
    rx_msg(m, sc, ok);
    chk({nm, "_rx_ok"}, 88'(ok), 88'(1));
    chk({nm, "_msg"}, m, vecs[i].msg);
    wait_idle(nm, sc);
    chk({nm, "_drop"}, 88'(bus.o_drop), 88'(vecs[i].drop));
  endtask

  initial begin
    logic [87:0] m;
    int sc;
    bit ok;
    int w;
    int starts;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, {"PASS 0001", 8'h0D, 8'h0A}, 16'h0001, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, {"FAIL 0002", 8'h0D, 8'h0A}, 16'h0001, 16'h0001, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 1'b0, {"PASS 0003", 8'h0D, 8'h0A}, 16'h0002, 16'h0001, 1'b0};
    vecs[3] = '{1'b1, 16'h0ABC, 16'h0003, 1'b1, {"FAIL 0ABD", 8'h0D, 8'h0A}, 16'h0003, 16'h0003, 1'b1};
    vecs[4] = '{1'b1, 16'hFFFE, 16'hFFFE, 1'b0, {"PASS FFFF", 8'h0D, 8'h0A}, 16'hFFFF, 16'h0003, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, {"PASS 0000", 8'h0D, 8'h0A}, 16'hFFFF, 16'h0003, 1'b1};

    bus.i_stop  = 1'b0;
    bus.i_error = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 88'(bus.o_txd), 88'(1));
    chk("rst_busy", 88'(bus.o_busy), 88'(0));
    chk("rst_drop", 88'(bus.o_drop), 88'(0));
    chk("rst_pass", 88'(bus.o_pass_cnt), 88'(0));
    chk("rst_fail", 88'(bus.o_fail_cnt), 88'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) run_vec(i);

    // Overlap: a second stop event lands inside byte 3 of a FAIL report.
    bus.i_stop  = 1'b0;
    bus.i_error = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b1;
    @(negedge clk);
    rx_idx = 0;
    fork
      rx_msg(m, sc, ok);
      begin
        w = 0;
        while (rx_idx != 3 && w < 2000) begin
          @(negedge clk);
          w++;
        end
        repeat (8) @(negedge clk);
        bus.i_stop  = 1'b0;
        bus.i_error = 1'b0;
        @(negedge clk);
        bus.i_stop = 1'b1;
      end
    join
    chk("ovl_rx_ok", 88'(ok), 88'(1));
    chk("ovl_msg", m, {"FAIL 0004", 8'h0D, 8'h0A});
    wait_idle("ovl", sc);
    chk("ovl_pass", 88'(bus.o_pass_cnt), 88'(16'h0003));
    chk("ovl_fail", 88'(bus.o_fail_cnt), 88'(16'h0002));
    chk("ovl_drop", 88'(bus.o_drop), 88'(1));
    count_starts(100, starts);
    chk("ovl_no_second", 88'(starts), 88'(0));

    for (int i = 3; i < 6; i++) run_vec(i);

    // Reset asserted while a low data bit of 'P' is on the line.
    bus.i_stop  = 1'b0;
    bus.i_error = 1'b0;
    @(negedge clk);
    bus.i_stop = 1'b1;
    w = 0;
    while (bus.o_txd !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    chk("mid_data_low", 88'(bus.o_txd), 88'(0));
    rst_n = 1'b0;
    #1;
    chk("mr_txd", 88'(bus.o_txd), 88'(1));
    chk("mr_busy", 88'(bus.o_busy), 88'(0));
    chk("mr_drop", 88'(bus.o_drop), 88'(0));
    chk("mr_pass", 88'(bus.o_pass_cnt), 88'(0));
    chk("mr_fail", 88'(bus.o_fail_cnt), 88'(0));
    bus.i_stop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rel_txd", 88'(bus.o_txd), 88'(1));

    // Stuck high: i_stop held for 2000 cycles yields a single report.
    bus.i_stop = 1'b1;
    rx_msg(m, sc, ok);
    chk("stk_rx_ok", 88'(ok), 88'(1));
    chk("stk_msg", m, {"PASS 0001", 8'h0D, 8'h0A});
    wait_idle("stk", sc);
    count_starts(1500, starts);
    chk("stk_one_msg", 88'(starts), 88'(0));
    chk("stk_pass", 88'(bus.o_pass_cnt), 88'(16'h0001));
    chk("stk_fail", 88'(bus.o_fail_cnt), 88'(16'h0000));
    chk("stk_busy", 88'(bus.o_busy), 88'(0));
    bus.i_stop = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
